cpu_step_ctrl: RTL and testbench
================================

# cpu_step_ctrl

- Multi-cycle sequencer for the single-issue teaching CPU.
- Steps each instruction through FETCH, DECODE, EXEC, optional MEM, and WB.
- Owns the instruction-ROM address and gates the register-file and data-memory write strobes.
- Sits between the clock-divider tick and the Ctrl/RF/DM datapath; provides run, single-step and (optional) breakpoint halt for board debugging.

## Interface
Parameters:
- PC_W, 4, instruction-ROM address width
- IM_CODE_NUM, 12, last valid ROM address; PC wraps to 0 after it

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- tick  in  1  one-clk-wide advance pulse from divider; FSM moves only when high
- run  in  1  level; free-run when 1
- step  in  1  one-clk pulse; execute one instruction when halted
- is_load  in  1  decoded instruction reads DM
- mem_write_req  in  1  Ctrl MemWrite
- reg_write_req  in  1  Ctrl RegWrite
- bp_addr  in  PC_W  breakpoint address (used only with BREAKPOINT_EN)
- rom_addr  out  PC_W  current PC index into ROM
- ir_load  out  1  instruction-register capture strobe
- dm_we  out  1  DM write strobe
- rf_we  out  1  RF write strobe
- state  out  3  FSM state code
- halted  out  1  state == IDLE
- bp_hit  out  1  halted by breakpoint
- instr_cnt  out  16  retired-instruction count

## Operation
- State codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5. Codes 6 and 7 are illegal and go to IDLE on the next clk.
- step_pend:
  - Internal flag, set by step while in IDLE.
  - Ignored outside IDLE.
  - Cleared when IDLE is left.
- Transitions, taken only on clk edges where tick=1:
  - IDLE→FETCH when run or step_pend; otherwise stay in IDLE.
  - FETCH→DECODE.
  - DECODE→EXEC.
  - EXEC→MEM if is_load or mem_write_req; otherwise EXEC→WB.
  - MEM→WB.
  - WB→FETCH if run and no breakpoint match; otherwise WB→IDLE.
- PC update at the WB-leaving edge:
  - rom_addr becomes 0 if rom_addr == IM_CODE_NUM; otherwise rom_addr+1.
  - instr_cnt increments, wrapping modulo 2^16.
- Strobes (combinational, one clk wide, aligned with the advancing edge):
  - ir_load = (state==FETCH) & tick.
  - dm_we = (state==MEM) & tick & mem_write_req.
  - rf_we = (state==WB) & tick & reg_write_req.
- Run deasserted mid-instruction: the current instruction completes through WB, then the FSM goes to IDLE.
- Step during run=1: no effect, because step is only captured in IDLE.

## Timing
- Reset (async, immediate):
  - state=IDLE, rom_addr=0, instr_cnt=0, bp_hit=0, step_pend=0.
  - halted=1; ir_load, dm_we, rf_we = 0.
- Each state lasts exactly one tick period; clk edges without tick change nothing.
- Instruction latency in ticks:
  - 4 (FETCH, DECODE, EXEC, WB) for non-memory instructions.
  - 5 when MEM is visited.
  - Plus 1 tick in IDLE when starting from halt.
- A step pulse arriving in the same clk as a tick in IDLE is captured and acted on at that same edge.
- Reset mid-instruction: no strobe may assert during or after the reset assertion; PC returns to 0.
- halted and bp_hit are registered outputs; the strobes are not registered.

## Configuration
- Macro: BREAKPOINT_EN.
- Defined:
  - At WB with run=1, if the next PC equals bp_addr, go to IDLE and set bp_hit=1.
  - bp_hit clears when IDLE is left.
  - Resuming does not recheck the breakpoint until the next WB.
- Undefined:
  - bp_addr is ignored.
  - bp_hit is tied to 0.
  - WB→FETCH depends on run alone.

## Test plan
- Reset, run=1, tick every 4 clk, all request inputs 0:
  - rom_addr steps 0→1→2 once per 4 ticks.
  - ir_load pulses once per instruction.
  - rf_we and dm_we stay 0.
- run=0, single step pulse, is_load=1, reg_write_req=1:
  - FSM visits 1,2,3,4,5 and returns to 0.
  - rf_we pulses once, in WB.
  - rom_addr 0→1; instr_cnt=1.
- run=1 for 13 instructions with IM_CODE_NUM=12:
  - rom_addr sequence ends 12→0.
  - instr_cnt=13.
- mem_write_req=1 store instruction:
  - dm_we pulses exactly once, in MEM.
  - Deasserting run during EXEC still completes WB, then halted=1.
- BREAKPOINT_EN defined, bp_addr=3, run=1:
  - Halts with rom_addr=3, bp_hit=1.
  - Next run resumes: bp_hit=0 and rom_addr reaches 4.
- rstn low while state=MEM with mem_write_req=1:
  - dm_we=0 and state=0 immediately.
  - rom_addr=0.

Source files
------------

// File: rtl/cpu_step_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : cpu_step_ctrl                                                    |
// | Brief   : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with run, single  |
// |           step and optional breakpoint halt (macro BREAKPOINT_EN).         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module cpu_step_ctrl #(
  parameter int PC_W        = 4,
  parameter int IM_CODE_NUM = 12
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            tick,
  input  logic            run,
  input  logic            step,
  input  logic            is_load,
  input  logic            mem_write_req,
  input  logic            reg_write_req,
  input  logic [PC_W-1:0] bp_addr,
  output logic [PC_W-1:0] rom_addr,
  output logic            ir_load,
  output logic            dm_we,
  output logic            rf_we,
  output logic [2:0]      state,
  output logic            halted,
  output logic            bp_hit,
  output logic [15:0]     instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [PC_W-1:0] c_last_pc = PC_W'(IM_CODE_NUM);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [15:0]     r_cnt;
  logic            r_step_pend;
  logic            r_halted;
  logic            w_bp_match;
  logic            w_leave_idle;
  logic            w_retire;

  assign w_pc_nxt = (r_pc == c_last_pc) ? '0 : r_pc + PC_W'(1);

`ifdef BREAKPOINT_EN
  assign w_bp_match = (w_pc_nxt == bp_addr);
`else
  logic w_unused_bp;
  assign w_bp_match  = 1'b0;
  assign w_unused_bp = ^bp_addr;
`endif

  // A step arriving together with a tick in IDLE is honoured on that same edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (tick && (run || r_step_pend || step)) w_state_nxt = S_FETCH;
      S_FETCH:  if (tick) w_state_nxt = S_DECODE;
      S_DECODE: if (tick) w_state_nxt = S_EXEC;
      S_EXEC:   if (tick) w_state_nxt = (is_load || mem_write_req) ? S_MEM : S_WB;
      S_MEM:    if (tick) w_state_nxt = S_WB;
      S_WB:     if (tick) w_state_nxt = (run && !w_bp_match) ? S_FETCH : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  assign w_leave_idle = (r_state == S_IDLE) && (w_state_nxt != S_IDLE);
  assign w_retire     = (r_state == S_WB) && tick;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_halted    <= 1'b1;
      r_pc        <= '0;
      r_cnt       <= '0;
      r_step_pend <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_halted <= (w_state_nxt == S_IDLE);
      if (w_leave_idle)
        r_step_pend <= 1'b0;
      else if ((r_state == S_IDLE) && step)
        r_step_pend <= 1'b1;
      if (w_retire) begin
        r_pc  <= w_pc_nxt;
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

`ifdef BREAKPOINT_EN
  logic r_bp_hit;

  // Cleared on resume, so the breakpoint is only re-evaluated at the next WB.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_bp_hit <= 1'b0;
    else if (w_leave_idle)
      r_bp_hit <= 1'b0;
    else if (w_retire && run && w_bp_match)
      r_bp_hit <= 1'b1;
  end

  assign bp_hit = r_bp_hit;
`else
  assign bp_hit = 1'b0;
`endif

  assign rom_addr  = r_pc;
  assign instr_cnt = r_cnt;
  assign state     = r_state;
  assign halted    = r_halted;
  assign ir_load   = (r_state == S_FETCH) && tick;
  assign dm_we     = (r_state == S_MEM) && tick && mem_write_req;
  assign rf_we     = (r_state == S_WB) && tick && reg_write_req;

endmodule
`default_nettype wire

// File: tb/tb_cpu_step_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_cpu_step_ctrl                                                 |
// | Brief   : Scoreboard bench for cpu_step_ctrl (honours BREAKPOINT_EN).      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_cpu_step_ctrl;

  localparam int PC_W        = 4;
  localparam int IM_CODE_NUM = 12;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            tick = 1'b0;
  logic            run = 1'b0;
  logic            step = 1'b0;
  logic            is_load = 1'b0;
  logic            mem_write_req = 1'b0;
  logic            reg_write_req = 1'b0;
  logic [PC_W-1:0] bp_addr = 4'd3;
  logic [PC_W-1:0] rom_addr;
  logic            ir_load;
  logic            dm_we;
  logic            rf_we;
  logic [2:0]      state;
  logic            halted;
  logic            bp_hit;
  logic [15:0]     instr_cnt;

  cpu_step_ctrl #(.PC_W(PC_W), .IM_CODE_NUM(IM_CODE_NUM)) dut (
    .clk(clk), .rstn(rstn), .tick(tick), .run(run), .step(step),
    .is_load(is_load), .mem_write_req(mem_write_req), .reg_write_req(reg_write_req),
    .bp_addr(bp_addr), .rom_addr(rom_addr), .ir_load(ir_load), .dm_we(dm_we),
    .rf_we(rf_we), .state(state), .halted(halted), .bp_hit(bp_hit),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [15:0]     cnt;
    logic [31:0]     seq;
    int              n_dm;
    int              n_rf;
    logic            halt;
    logic            bph;
  } exp_t;

  exp_t            sb[$];
  logic [PC_W-1:0] m_pc;
  logic [15:0]     m_cnt;
  logic            m_halted;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected outcome of one instruction; the visited-state trace is nibble-packed behind an F marker.
  task automatic push_exp(input logic mem, input logic mw, input logic rw, input logic stop_run);
    exp_t            e;
    logic [PC_W-1:0] nx;
    nx    = (m_pc == PC_W'(IM_CODE_NUM)) ? '0 : m_pc + PC_W'(1);
    e.seq = 32'hF;
    if (m_halted) e.seq = e.seq << 4;
    e.seq = (e.seq << 12) | 32'h123;
    if (mem) e.seq = (e.seq << 4) | 32'h4;
    e.seq  = (e.seq << 4) | 32'h5;
    e.pc   = nx;
    e.cnt  = m_cnt + 16'd1;
    e.n_dm = (mem && mw) ? 1 : 0;
    e.n_rf = rw ? 1 : 0;
    e.halt = stop_run;
    e.bph  = 1'b0;
`ifdef BREAKPOINT_EN
    if (!stop_run && nx == bp_addr) begin
      e.halt = 1'b1;
      e.bph  = 1'b1;
    end
`endif
    m_pc     = e.pc;
    m_cnt    = e.cnt;
    m_halted = e.halt;
    sb.push_back(e);
  endtask

  // mode 0: run=1; mode 1: step pulse before the first tick; mode 2: step together with the first tick.
  task automatic instr(input logic ld, input logic mw, input logic rw, input logic stop, input int mode);
    exp_t        e;
    logic [31:0] seq;
    logic [2:0]  st;
    logic [2:0]  st_hold;
    int          n_ir;
    int          n_dm;
    int          n_rf;
    logic        done;
    is_load       = ld;
    mem_write_req = mw;
    reg_write_req = rw;
    run           = (mode == 0);
    push_exp(ld | mw, mw, rw, stop || (mode != 0));
    if (mode == 1) begin
      @(negedge clk);
      step = 1'b1;
      @(posedge clk); #1;
      step = 1'b0;
    end
    seq  = 32'hF;
    n_ir = 0; n_dm = 0; n_rf = 0;
    done = 1'b0;
    for (int t = 0; t < 10 && !done; t++) begin
      @(negedge clk);
      if (stop && state == 3'd3) run = 1'b0;
      if (mode == 2 && t == 0) step = 1'b1;
      tick = 1'b1;
      #1;
      st  = state;
      seq = (seq << 4) | {29'b0, st};
      if (ir_load) n_ir++;
      if (dm_we) begin n_dm++; chk("dm_we_state", 32'(state), 32'd4); end
      if (rf_we) begin n_rf++; chk("rf_we_state", 32'(state), 32'd5); end
      @(posedge clk); #1;
      tick = 1'b0;
      step = 1'b0;
      if (st == 3'd5) done = 1'b1;
      st_hold = state;
      repeat (3) @(posedge clk);
      #1;
      chk("hold_no_tick", 32'(state), 32'(st_hold));
    end
    if (!done) chk("retire_timeout", 32'd0, 32'd1);
    e = sb.pop_front();
    chk("rom_addr", 32'(rom_addr), 32'(e.pc));
    chk("instr_cnt", 32'(instr_cnt), 32'(e.cnt));
    chk("state_trace", seq, e.seq);
    chk("ir_load_cnt", 32'(n_ir), 32'd1);
    chk("dm_we_cnt", 32'(n_dm), 32'(e.n_dm));
    chk("rf_we_cnt", 32'(n_rf), 32'(e.n_rf));
    chk("halted", 32'(halted), 32'(e.halt));
    chk("state_after", 32'(state), e.halt ? 32'd0 : 32'd1);
    chk("bp_hit", 32'(bp_hit), 32'(e.bph));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    #12;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_instr_cnt", 32'(instr_cnt), 32'd0);
    chk("rst_halted", 32'(halted), 32'd1);
    chk("rst_bp_hit", 32'(bp_hit), 32'd0);
    tick = 1'b1; run = 1'b1; mem_write_req = 1'b1; reg_write_req = 1'b1;
    #1;
    chk("rst_strobes", {29'b0, ir_load, dm_we, rf_we}, 32'd0);
    tick = 1'b0; run = 1'b0; mem_write_req = 1'b0; reg_write_req = 1'b0;
    @(negedge clk);
    rstn     = 1'b1;
    m_pc     = '0;
    m_cnt    = '0;
    m_halted = 1'b1;

    // Free run across the ROM end; the last instruction drops run in EXEC.
    for (int i = 0; i < 13; i++) instr(1'b0, 1'b0, 1'b0, (i == 12), 0);
    chk("wrap_rom_addr", 32'(rom_addr), 32'd0);
    chk("wrap_instr_cnt", 32'(instr_cnt), 32'd13);

    instr(1'b1, 1'b0, 1'b1, 1'b0, 1);
    instr(1'b0, 1'b0, 1'b1, 1'b0, 2);
    instr(1'b0, 1'b1, 1'b0, 1'b1, 0);
    instr(1'b1, 1'b0, 1'b1, 1'b0, 0);
    instr(1'b0, 1'b0, 1'b1, 1'b1, 0);

    // Reset asserted while a store sits in MEM.
    is_load = 1'b0; mem_write_req = 1'b1; reg_write_req = 1'b0; run = 1'b1;
    guard = 0;
    @(negedge clk);
    while (state != 3'd4 && guard < 12) begin
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      @(negedge clk);
      guard++;
    end
    chk("reach_mem", 32'(state), 32'd4);
    tick = 1'b1;
    #1;
    chk("pre_rst_dm_we", 32'(dm_we), 32'd1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_dm_we", 32'(dm_we), 32'd0);
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("mid_rst_instr_cnt", 32'(instr_cnt), 32'd0);
    chk("mid_rst_halted", 32'(halted), 32'd1);
    @(posedge clk); #1;
    chk("in_rst_dm_we", 32'(dm_we), 32'd0);
    chk("in_rst_state", 32'(state), 32'd0);
    tick = 1'b0; run = 1'b0; mem_write_req = 1'b0;
    @(negedge clk);
    rstn     = 1'b1;
    m_pc     = '0;
    m_cnt    = '0;
    m_halted = 1'b1;

    instr(1'b0, 1'b0, 1'b1, 1'b0, 0);
    instr(1'b0, 1'b0, 1'b0, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
